pipe_reg_chain: RTL and testbench
=================================

// Module: pipe_reg_chain
// PURPOSE
//   Parametrised chain of enabled registers (WIDTH bits x DEPTH stages) with valid/ready
//   flow control, bubble collapsing and synchronous flush. General-purpose delay/retiming
//   element between datapath blocks, with backpressure.
//   Successor to the single-bit enabled flop: data only loads when a stage accepts.
// PARAMETERS
//   WIDTH      8   data width per stage, >= 1
//   DEPTH      4   number of register stages, >= 1; DEPTH < 1 is an elaboration error
//   RESET_VAL  0   value of every data register after reset, WIDTH bits
// PORTS
//   clk        in   1              clock, all state updates on rising edge
//   reset      in   1              synchronous, active-high
//   flush      in   1              synchronous, active-high; discards all held items
//   in_valid   in   1              upstream item present
//   in_ready   out  1              chain can accept in_data this cycle
//   in_data    in   WIDTH          upstream payload
//   out_valid  out  1              last stage holds an item
//   out_ready  in   1              downstream accepts out_data this cycle
//   out_data   out  WIDTH          payload of last stage
//   occupancy  out  $clog2(DEPTH+1)  number of stages currently holding valid items
// BEHAVIOUR
//   - State per stage i (0 = input side, DEPTH-1 = output side): vld[i], dat[i].
//   - Reset (priority over flush): vld[*] <= 0, dat[*] <= RESET_VAL. Outputs after reset:
//     out_valid=0, out_data=RESET_VAL, occupancy=0, in_ready=1 (when flush=0).
//   - Stage ready: rdy[DEPTH-1] = !vld[DEPTH-1] | out_ready;
//     rdy[i] = !vld[i] | rdy[i+1] for i < DEPTH-1. in_ready = rdy[0] & !flush.
//     Ready is combinational through the chain (bubble collapsing); no comb path
//     from in_valid to in_ready.
//   - Stage i loads (enable) when rdy[i]: vld[i] <= upstream valid, dat[i] <= upstream
//     data only when the upstream valid is 1 (data held otherwise; no toggling on bubbles).
//   - Transfers: input when in_valid & in_ready; output when out_valid & out_ready.
//     Holding in_valid with in_ready=0 leaves the chain unchanged at that boundary.
//   - Latency: item accepted at edge N appears on out_valid after edge N+DEPTH-1 when
//     no backpressure (i.e. DEPTH cycles register-to-register). Throughput 1 item/cycle
//     with out_ready held 1.
//   - Backpressure: out_ready=0 with all stages valid -> in_ready=0, nothing moves, no
//     data lost or duplicated. Partial fill: empty stages absorb items until full.
//   - Flush (reset=0): out_valid and in_ready forced 0 in the flush cycle (no transfer
//     on either side); vld[*] <= 0 at the edge; dat[*] retained. occupancy 0 next cycle.
//   - occupancy = popcount(vld); registered-state derived, range 0..DEPTH.
//   - Order preserved: FIFO ordering, no reordering or drops except by flush/reset.
//   - Reset or flush mid-stream: items in flight are discarded; accept resumes the
//     cycle after deassertion.
// STRUCTURE
//   - Shared package: none required; WIDTH/DEPTH passed as parameters. The occupancy
//     width function (clog2 of DEPTH+1) goes in the team's common utilities package.
//   - One sub-module: pipe_reg_stage (WIDTH, RESET_VAL): vld/dat pair with up/down
//     valid-ready; chain generated with a generate loop of DEPTH instances.
// TESTING
//   1 Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, occupancy=0,
//     out_data=RESET_VAL; after release in_ready=1.
//   2 Streaming DEPTH=4: in 0x01..0x10 back-to-back, out_ready=1 -> first out_valid
//     4 cycles after first accept, outputs 0x01..0x10 in order, one per cycle.
//   3 Backpressure: out_ready=0, push 6 items -> 4 accepted, in_ready=0, occupancy=4;
//     release out_ready -> 4 drained in order, then items 5 and 6.
//   4 Bubble collapse: push 0xA1, idle 3 cycles, out_ready=0, push 0xA2..0xA4 -> all
//     accepted (occupancy=4), out order A1,A2,A3,A4.
//   5 Flush: occupancy=3, assert flush 1 cycle with in_valid=1, out_ready=1 -> no
//     transfer that cycle, occupancy=0 next; subsequent push 0x55 emerges alone.
//   6 DEPTH=1, WIDTH=1: simultaneous in and out transfer every cycle -> full rate, in_ready=1.

Source files
------------

// File: rtl/pipe_reg_chain_pkg.sv
// Common utilities for the pipe_reg_chain slice: width helpers shared by the
// chain top and its bench.
package pipe_reg_chain_pkg;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int occ_width(input int depth);
    if (depth < 1) begin
      return 1;
    end
    return (depth + 1 > 2) ? $clog2(depth + 1) : 1;
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One register slot of the chain: a valid bit plus a payload register, with a
// valid/ready handshake on both sides. The slot accepts whenever it is empty
// or its downstream neighbour is taking its current item, so empty slots
// anywhere in the chain are filled (bubble collapsing).
module pipe_reg_stage
  import pipe_reg_chain_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             up_ready_o,
  input  logic             dn_ready_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  if (WIDTH < 1) begin : g_bad_width
    $error("pipe_reg_stage: WIDTH must be >= 1");
  end

  // Ready ripples back combinationally: an empty slot always takes a new item.
  assign up_ready_o = ~vld_q | dn_ready_i;

  // Next state: flush drops the item but keeps the payload; payload only
  // loads on a real item so bubbles never toggle the data register.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (up_ready_o) begin
      vld_d = up_valid_i;
      if (up_valid_i) begin
        dat_d = up_data_i;
      end
    end
  end

  // Slot registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      dat_q <= RESET_VAL;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Parametrised delay/retiming chain of DEPTH register slots with valid/ready
// flow control, bubble collapsing and synchronous flush. Items leave in the
// order they entered; only flush or reset discards them.
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              OCC_W     = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0] vld_all;
  logic [OCC_W-1:0] occ_sum;

  // Slot 0 faces the input, slot DEPTH-1 drives the output. Each slot's
  // downstream ready is its neighbour's upstream ready, giving the
  // combinational ready chain; valid/data move forward through registers.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             up_ready;
    logic             dn_ready;
    logic             vld;
    logic [WIDTH-1:0] dat;

    if (i == 0) begin : g_first
      assign up_valid = in_valid & ~flush;
      assign up_data  = in_data;
    end else begin : g_mid
      assign up_valid = g_stage[i-1].vld;
      assign up_data  = g_stage[i-1].dat;
    end

    if (i == DEPTH - 1) begin : g_last
      assign dn_ready = out_ready;
    end else begin : g_link
      assign dn_ready = g_stage[i+1].up_ready;
    end

    pipe_reg_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .up_valid_i (up_valid),
      .up_data_i  (up_data),
      .up_ready_o (up_ready),
      .dn_ready_i (dn_ready),
      .vld_o      (vld),
      .dat_o      (dat)
    );

    assign vld_all[i] = vld;
  end

  // During flush neither side may transfer.
  assign in_ready  = g_stage[0].up_ready & ~flush;
  assign out_valid = g_stage[DEPTH-1].vld & ~flush;
  assign out_data  = g_stage[DEPTH-1].dat;

  // Occupancy is the population count of the registered valid bits.
  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_sum = occ_sum + OCC_W'(vld_all[i]);
    end
  end

  assign occupancy = occ_sum;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain: directed table, hand-written
// corner sequences and a randomized run against a queue-based model.
module tb_pipe_reg_chain;

  localparam logic [7:0] RV = 8'hC3;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] occupancy;

  logic       d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
  logic [0:0] d1_in_data, d1_out_data, d1_occ;
  logic       d1_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_reg_chain #(.WIDTH(8), .DEPTH(D), .RESET_VAL(RV)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_reg_chain #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_d1 (
    .clk(clk), .reset(reset), .flush(d1_flush),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
    .occupancy(d1_occ)
  );

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic       chk_od;
    logic [7:0] e_od;
    logic [2:0] e_occ;
  } vec_t;

  vec_t       tbl[13];
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  int         first_acc, first_out, sent, rcvd, n_out;
  logic       exp_ir, prev_bit, cur_bit, fl_r, iv_r, or_r;
  logic [7:0] d_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // inputs are driven just after the rising edge; outputs sampled on the falling edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b0;
    d1_in_valid = 1'b0; d1_in_data = 1'b0; d1_out_ready = 1'b0; d1_flush = 1'b0;

    // ---- 1: reset held 2 cycles with in_valid=1
    next_cycle();
    next_cycle();
    sample();
    chk("reset out_valid", out_valid, 0);
    chk("reset occupancy", occupancy, 0);
    chk("reset out_data", out_data, RV);
    next_cycle();
    reset = 1'b0;
    drive(0, 8'h00, 0, 0);
    sample();
    chk("post-reset in_ready", in_ready, 1);
    chk("post-reset occupancy", occupancy, 0);
    chk("post-reset out_valid", out_valid, 0);

    // ---- 2: streaming 0x01..0x10, out_ready=1
    sent = 0; rcvd = 0; first_acc = -1; first_out = -1;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      drive(sent < 16, 8'(sent + 1), 1, 0);
      sample();
      if (out_valid) begin
        if (first_out < 0) first_out = c;
        chk("stream data", out_data, 32'(rcvd + 1));
        chk("stream one-per-cycle", c, 32'(first_out + rcvd));
        rcvd++;
      end
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = c;
        sent++;
      end
    end
    chk("stream sent", sent, 16);
    chk("stream received", rcvd, 16);
    chk("stream latency", first_out - first_acc, D);

    // ---- 3: backpressure table
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[1]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd1};
    tbl[2]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd2};
    tbl[3]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3};
    tbl[4]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 3'd4};
    tbl[5]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 3'd4};
    tbl[6]  = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 3'd4};
    tbl[7]  = '{1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 3'd4};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 3'd4};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 3'd3};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 3'd2};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h06, 3'd1};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h06, 3'd0};
    for (int r = 0; r < 13; r++) begin
      next_cycle();
      drive(tbl[r].iv, tbl[r].d, tbl[r].ordy, 0);
      sample();
      chk($sformatf("bp[%0d] in_ready", r), in_ready, tbl[r].e_ir);
      chk($sformatf("bp[%0d] out_valid", r), out_valid, tbl[r].e_ov);
      chk($sformatf("bp[%0d] occupancy", r), occupancy, tbl[r].e_occ);
      if (tbl[r].chk_od) chk($sformatf("bp[%0d] out_data", r), out_data, tbl[r].e_od);
    end

    // ---- 4: bubble collapse
    next_cycle(); drive(1, 8'hA1, 0, 0);
    for (int i = 0; i < 3; i++) begin next_cycle(); drive(0, 8'h00, 0, 0); end
    for (int i = 0; i < 3; i++) begin
      next_cycle(); drive(1, 8'(8'hA2 + i), 0, 0);
      sample();
      chk("bubble in_ready", in_ready, 1);
    end
    next_cycle(); drive(0, 8'h00, 0, 0);
    sample();
    chk("bubble occupancy", occupancy, 4);
    chk("bubble full in_ready", in_ready, 0);
    n_out = 0;
    for (int c = 0; c < 10; c++) begin
      next_cycle(); drive(0, 8'h00, 1, 0);
      sample();
      if (out_valid) begin
        chk("bubble order", out_data, 32'(8'hA1 + n_out));
        n_out++;
      end
    end
    chk("bubble drained count", n_out, 4);

    // ---- 5: flush with 3 items held
    for (int i = 0; i < 3; i++) begin next_cycle(); drive(1, 8'(8'h31 + i), 0, 0); end
    next_cycle(); drive(1, 8'h77, 1, 1);
    sample();
    chk("flush occupancy before", occupancy, 3);
    chk("flush in_ready", in_ready, 0);
    chk("flush out_valid", out_valid, 0);
    next_cycle(); drive(0, 8'h00, 0, 0);
    sample();
    chk("flush occupancy after", occupancy, 0);
    chk("flush out_valid after", out_valid, 0);
    next_cycle(); drive(1, 8'h55, 1, 0);
    sample();
    chk("post-flush in_ready", in_ready, 1);
    n_out = 0;
    for (int c = 0; c < 8; c++) begin
      next_cycle(); drive(0, 8'h00, 1, 0);
      sample();
      if (out_valid) begin
        chk("post-flush data", out_data, 8'h55);
        n_out++;
      end
    end
    chk("post-flush item count", n_out, 1);
    chk("post-flush occupancy", occupancy, 0);

    // ---- 6: DEPTH=1 WIDTH=1 full rate
    prev_bit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      cur_bit = 1'($urandom_range(0, 1));
      d1_in_valid = 1'b1; d1_out_ready = 1'b1; d1_in_data = cur_bit;
      sample();
      chk("d1 in_ready", d1_in_ready, 1);
      chk("d1 out_valid", d1_out_valid, (c > 0));
      if (c > 0) chk("d1 out_data", d1_out_data, prev_bit);
      chk("d1 occupancy", d1_occ, (c > 0));
      prev_bit = cur_bit;
    end
    next_cycle(); d1_in_valid = 1'b0;

    // ---- randomized run against a FIFO model
    q.delete();
    for (int c = 0; c < 800; c++) begin
      next_cycle();
      fl_r = ($urandom_range(0, 31) == 0);
      iv_r = ($urandom_range(0, 2) != 0);
      or_r = ($urandom_range(0, 1) != 0);
      d_r  = 8'($urandom);
      drive(iv_r, d_r, or_r, fl_r);
      sample();
      exp_ir = !fl_r && (q.size() < D || or_r);
      chk("rand in_ready", in_ready, exp_ir);
      chk("rand occupancy", occupancy, q.size());
      if (fl_r) chk("rand flush out_valid", out_valid, 0);
      else if (q.size() == D) chk("rand full out_valid", out_valid, 1);
      if (q.size() == 0) chk("rand empty out_valid", out_valid, 0);
      if (fl_r) begin
        q.delete();
      end else begin
        if (out_valid && or_r && q.size() > 0) begin
          chk("rand out_data", out_data, q[0]);
          void'(q.pop_front());
        end
        if (iv_r && exp_ir) q.push_back(d_r);
      end
    end
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      next_cycle(); drive(0, 8'h00, 1, 0);
      sample();
      if (out_valid) begin
        chk("drain out_data", out_data, q[0]);
        void'(q.pop_front());
      end
    end
    chk("drain model empty", q.size(), 0);
    next_cycle(); drive(0, 8'h00, 1, 0);
    sample();
    chk("drain occupancy", occupancy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
